// File: rtl/idct_unshuffle_ram_pkg.sv
// Shared definitions for the IDCT output unshuffle buffer.
package idct_unshuffle_ram_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  localparam int unsigned RAM_AW     = 10;
  localparam int unsigned RAM_RD_LAT = 1;
  localparam int unsigned CNT_W      = 12;

endpackage

// File: rtl/idct_unshuffle_ram_if.sv
// Avalon-ST style sample stream with frame delimiters and frame length.
interface idct_unshuffle_ram_if #(
  parameter int unsigned W = 28
);
  logic         valid;
  logic         ready;
  logic [1:0]   error;
  logic         sop;
  logic         eop;
  logic [W-1:0] data_real;
  logic [W-1:0] data_imag;
  logic [11:0]  fftpts;

  modport master (
    output valid, error, sop, eop, data_real, data_imag, fftpts,
    input  ready
  );

  modport slave (
    input  valid, error, sop, eop, data_real, data_imag, fftpts,
    output ready
  );
endinterface

// File: rtl/idct_unshuffle_ram_ram.sv
// Simple dual-port RAM, registered read, no reset on contents.
module RAM_dct_vecRot #(
  parameter int unsigned DW = 56,
  parameter int unsigned AW = 10
) (
  input  logic          clock,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] rdaddress,
  input  logic [AW-1:0] wraddress,
  input  logic          wren,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [1 << AW];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
    q <= mem[rdaddress];
  end

endmodule

// File: rtl/idct_unshuffle_ram.sv
// Reorders one IFFT frame v(k) into x(2n)=v(n), x(2n+1)=v(N-1-n).
// First half of the frame lives in RAM0, second half in RAM1.
module idct_unshuffle_ram
  import idct_unshuffle_ram_pkg::*;
#(
  parameter int unsigned wDataIn  = 28,
  parameter int unsigned wDataOut = 28
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  idct_unshuffle_ram_if.slave   sink,
  idct_unshuffle_ram_if.master  source
);

  localparam int unsigned DW = 2 * wDataIn;

  state_t                state_q;
  logic                  sink_ready_q;
  logic [CNT_W-1:0]      wr_cnt_q;
  logic [CNT_W-1:0]      n_rd_q;
  logic [10:0]           rd_cnt_q;
  logic                  rd_done_q;

  logic [RAM_RD_LAT-1:0] v_pipe_q;
  logic [RAM_RD_LAT-1:0] odd_pipe_q;
  logic [RAM_RD_LAT-1:0] first_pipe_q;
  logic [RAM_RD_LAT-1:0] last_pipe_q;

  logic                  source_valid_q;
  logic                  source_sop_q;
  logic                  source_eop_q;
  logic [wDataOut-1:0]   source_real_q;
  logic [wDataOut-1:0]   source_imag_q;

  logic [CNT_W-1:0]      half;
  logic                  wr_active;
  logic                  wr_lower;
  logic                  wr_in_frame;
  logic                  we0;
  logic                  we1;
  logic [RAM_AW-1:0]     waddr0;
  logic [RAM_AW-1:0]     waddr1;
  logic [DW-1:0]         wdata;
  logic                  rd_en;
  logic                  rd_first;
  logic                  rd_last;
  logic [RAM_AW-1:0]     raddr0;
  logic [RAM_AW-1:0]     raddr1;
  logic [DW-1:0]         q0;
  logic [DW-1:0]         q1;

  // Write-side address decode.
  assign half        = {1'b0, sink.fftpts[11:1]};
  assign wr_active   = ((state_q == S_WAIT) || (state_q == S_WRITE)) && sink.valid;
  assign wr_lower    = wr_cnt_q < half;
  assign wr_in_frame = wr_cnt_q < sink.fftpts;
  assign we0         = wr_active && wr_lower;
  assign we1         = wr_active && !wr_lower && wr_in_frame;
  assign waddr0      = wr_cnt_q[RAM_AW-1:0];
  // Offset fits in RAM_AW bits, so modular subtraction on the low bits is exact.
  assign waddr1      = wr_cnt_q[RAM_AW-1:0] - half[RAM_AW-1:0];
  assign wdata       = {sink.data_real, sink.data_imag};

  // Read-side address decode.
  assign rd_en    = (state_q == S_READ) && !rd_done_q;
  assign rd_first = rd_en && (rd_cnt_q == '0);
  assign rd_last  = ({1'b0, rd_cnt_q} == (n_rd_q - 12'd1));
  assign raddr0   = rd_cnt_q[10:1];
  assign raddr1   = n_rd_q[10:1] - 10'd1 - rd_cnt_q[10:1];

  RAM_dct_vecRot #(.DW(DW), .AW(RAM_AW)) u_ram0 (
    .clock     (clk),
    .data      (wdata),
    .rdaddress (raddr0),
    .wraddress (waddr0),
    .wren      (we0),
    .q         (q0)
  );

  RAM_dct_vecRot #(.DW(DW), .AW(RAM_AW)) u_ram1 (
    .clock     (clk),
    .data      (wdata),
    .rdaddress (raddr1),
    .wraddress (waddr1),
    .wren      (we1),
    .q         (q1)
  );

  // Frame FSM with write/read counters and registered sink_ready.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q      <= S_WAIT;
      sink_ready_q <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      rd_done_q    <= 1'b0;
      n_rd_q       <= '0;
    end else begin
      sink_ready_q <= (state_q == S_WAIT) || (state_q == S_WRITE);
      case (state_q)
        S_WAIT: begin
          rd_cnt_q  <= '0;
          rd_done_q <= 1'b0;
          if (sink.valid) wr_cnt_q <= wr_cnt_q + 12'd1;
          if (sink.valid && sink.sop) state_q <= S_WRITE;
        end
        S_WRITE: begin
          rd_cnt_q  <= '0;
          rd_done_q <= 1'b0;
          if (sink.valid) wr_cnt_q <= wr_cnt_q + 12'd1;
          if (sink.valid && sink.eop) state_q <= S_HOLD;
        end
        S_HOLD: begin
          wr_cnt_q  <= '0;
          rd_cnt_q  <= '0;
          rd_done_q <= 1'b0;
          if (source.ready) begin
            state_q <= S_READ;
            n_rd_q  <= sink.fftpts;
          end
        end
        S_READ: begin
          wr_cnt_q <= '0;
          if (rd_en) begin
            rd_cnt_q <= rd_cnt_q + 11'd1;
            if (rd_last) rd_done_q <= 1'b1;
          end
          if (source_eop_q) begin
            state_q   <= S_WAIT;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  // Control pipeline matched to RAM latency, then registered source outputs.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      v_pipe_q       <= '0;
      odd_pipe_q     <= '0;
      first_pipe_q   <= '0;
      last_pipe_q    <= '0;
      source_valid_q <= 1'b0;
      source_sop_q   <= 1'b0;
      source_eop_q   <= 1'b0;
      source_real_q  <= '0;
      source_imag_q  <= '0;
    end else begin
      v_pipe_q[0]     <= rd_en;
      odd_pipe_q[0]   <= rd_cnt_q[0];
      first_pipe_q[0] <= rd_first;
      last_pipe_q[0]  <= rd_en && rd_last;
      for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
        v_pipe_q[i]     <= v_pipe_q[i-1];
        odd_pipe_q[i]   <= odd_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
        last_pipe_q[i]  <= last_pipe_q[i-1];
      end
      source_valid_q <= v_pipe_q[RAM_RD_LAT-1];
      source_sop_q   <= first_pipe_q[RAM_RD_LAT-1];
      source_eop_q   <= last_pipe_q[RAM_RD_LAT-1];
      if (v_pipe_q[RAM_RD_LAT-1]) begin
        if (odd_pipe_q[RAM_RD_LAT-1]) begin
          source_real_q <= q1[DW-1:wDataIn];
          source_imag_q <= q1[wDataIn-1:0];
        end else begin
          source_real_q <= q0[DW-1:wDataIn];
          source_imag_q <= q0[wDataIn-1:0];
        end
      end
    end
  end

  assign sink.ready        = sink_ready_q;
  assign source.valid      = source_valid_q;
  assign source.sop        = source_sop_q;
  assign source.eop        = source_eop_q;
  assign source.data_real  = source_real_q;
  assign source.data_imag  = source_imag_q;
  assign source.error      = '0;
  assign source.fftpts     = sink.fftpts;

endmodule
